// File: rtl/serial_link_pkg.sv
// ============================================================================
// Module  : serial_link_pkg
// Brief   : Shared definitions for the serial bit-stream link (state codes,
//           link-wide default word width, counter sizing helper).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_link_pkg;

    localparam int LINK_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ============================================================================
// Module  : piso_shift_reg
// Brief   : Parallel-load, shift-left register presenting its MSB serially.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q;

    // Zero fill on shift: once the last bit has left, the MSB reads 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
// ============================================================================
// Module  : serial_pattern_tx
// Brief   : Word-to-serial transmitter, MSB first, with optional repeated
//           copies separated by a fixed run of zero gap bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_pattern_tx
    import serial_link_pkg::*;
#(
    parameter int WIDTH    = LINK_WIDTH,
    parameter int REPEAT_W = 4,
    parameter int GAP_LEN  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [WIDTH-1:0]    load_data,
    input  logic [REPEAT_W-1:0] load_repeat,
    input  logic                abort,
    output logic                out,
    output logic                out_valid,
    output logic                frame_start,
    output logic                done
);

    localparam int BIT_W = cnt_width(WIDTH);
    localparam int GAP_W = cnt_width(GAP_LEN);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    tx_state_e             state_q, state_d;
    logic [WIDTH-1:0]      word_q, word_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [REPEAT_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  done_q, done_d;

    logic                  sr_load;
    logic                  sr_shift;
    logic [WIDTH-1:0]      sr_data;

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_data),
        .msb_o   (out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            word_q        <= '0;
            bit_cnt_q     <= '0;
            rep_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            bit_cnt_q     <= bit_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        bit_cnt_d     = bit_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;
        sr_data       = word_q;

        case (state_q)
            IDLE: begin
                if (load_valid && !abort) begin
                    word_d        = load_data;
                    rep_cnt_d     = load_repeat;
                    bit_cnt_d     = '0;
                    sr_load       = 1'b1;
                    sr_data       = load_data;
                    out_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    state_d       = SHIFT;
                end
            end

            SHIFT: begin
                if (abort) begin
                    // Loading zeros drops the serial line in the same edge.
                    sr_load   = 1'b1;
                    sr_data   = '0;
                    bit_cnt_d = '0;
                    rep_cnt_d = '0;
                    state_d   = IDLE;
                end else if (bit_cnt_q != BIT_LAST) begin
                    sr_shift    = 1'b1;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = '0;
                    if (rep_cnt_q == '0) begin
                        sr_shift = 1'b1;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else if (GAP_LEN == 0) begin
                        sr_load       = 1'b1;
                        rep_cnt_d     = rep_cnt_q - 1'b1;
                        out_valid_d   = 1'b1;
                        frame_start_d = 1'b1;
                    end else begin
                        sr_shift  = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    gap_cnt_d = '0;
                    rep_cnt_d = '0;
                    state_d   = IDLE;
                end else if (gap_cnt_q == GAP_LAST) begin
                    sr_load       = 1'b1;
                    rep_cnt_d     = rep_cnt_q - 1'b1;
                    gap_cnt_d     = '0;
                    out_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    state_d       = SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_ready  = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;

endmodule

`default_nettype wire
